// File: rtl/cal_sequencer.sv
// Gyro calibration sequencer: grants cmd/auto calibration requests, waits for the robot
// to settle, pulses the integrator start and supervises completion or timeout.
module cal_sequencer #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_cal,
  input  logic auto_en,
  input  logic moving,
  input  logic rdy,
  input  logic cal_done,
  output logic strt_cal,
  output logic mv_en,
  output logic cal_busy,
  output logic cal_ok,
  output logic cal_err,
  output logic src
);

  localparam int unsigned SETTLE_W = 7;
  localparam int unsigned TMO_W    = 13;
  localparam int unsigned AUTO_W   = 15;

  localparam logic [SETTLE_W-1:0] SETTLE_N = FAST_SIM ? SETTLE_W'(4)  : SETTLE_W'(64);
  localparam logic [TMO_W-1:0]    TMO_N    = FAST_SIM ? TMO_W'(16)    : TMO_W'(4096);
  localparam logic [AUTO_W-1:0]   AUTO_N   = FAST_SIM ? AUTO_W'(32)   : AUTO_W'(16384);

  typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT} state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [AUTO_W-1:0]   auto_q, auto_d;
  logic                pend_q, pend_d;
  logic                auto_req_q, auto_req_d;
  logic                cal_ok_q, cal_ok_d;
  logic                cal_err_q, cal_err_d;
  logic                src_q, src_d;
  logic                grant_cmd, grant_auto;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      tmo_q      <= '0;
      auto_q     <= '0;
      pend_q     <= 1'b0;
      auto_req_q <= 1'b0;
      cal_ok_q   <= 1'b0;
      cal_err_q  <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      auto_q     <= auto_d;
      pend_q     <= pend_d;
      auto_req_q <= auto_req_d;
      cal_ok_q   <= cal_ok_d;
      cal_err_q  <= cal_err_d;
      src_q      <= src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    auto_d     = auto_q;
    pend_d     = pend_q;
    auto_req_d = auto_req_q;
    cal_ok_d   = cal_ok_q;
    cal_err_d  = cal_err_q;
    src_d      = src_q;

    // A command (live or pending) always beats a pending auto request.
    grant_cmd  = (state_q == IDLE) && (cmd_cal || pend_q);
    grant_auto = (state_q == IDLE) && !grant_cmd && auto_req_q;

    case (state_q)
      IDLE: begin
        if (grant_cmd || grant_auto) begin
          state_d  = SETTLE;
          settle_d = '0;
          src_d    = grant_auto;
        end
      end
      SETTLE: begin
        if (moving) begin
          settle_d = '0;
        end else if (rdy && (settle_q != SETTLE_N)) begin
          settle_d = settle_q + SETTLE_W'(1);
        end
        if (settle_d == SETTLE_N) begin
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdy && (tmo_q != TMO_N)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (cal_done) begin
          cal_ok_d  = 1'b1;
          cal_err_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo_d == TMO_N) begin
          cal_ok_d  = 1'b0;
          cal_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase

    // One-deep command queue for requests arriving mid-calibration.
    if (grant_cmd) begin
      pend_d = 1'b0;
    end else if (cmd_cal && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    // Drift timer only advances while parked, enabled, calibrated and stationary.
    if (grant_cmd || grant_auto || moving || !auto_en) begin
      auto_d = '0;
    end else if ((state_q == IDLE) && cal_ok_q && rdy && (auto_q != AUTO_N)) begin
      auto_d = auto_q + AUTO_W'(1);
    end

    if (grant_cmd || grant_auto || moving) begin
      auto_req_d = 1'b0;
    end else if (auto_d == AUTO_N) begin
      auto_req_d = 1'b1;
    end
  end

  assign strt_cal = (state_q == START);
  assign cal_busy = (state_q != IDLE);
  assign mv_en    = moving & ~cal_busy;
  assign cal_ok   = cal_ok_q;
  assign cal_err  = cal_err_q;
  assign src      = src_q;

endmodule

// File: tb/tb_cal_sequencer.sv
// Bench for cal_sequencer (FAST_SIM): directed scenarios plus a randomized run against a
// count-down behavioural model of the calibration sequence.
module tb_cal_sequencer;

  localparam int SN = 4;
  localparam int TN = 16;
  localparam int AN = 32;

  logic clk;
  logic rst, cmd_cal, auto_en, moving, rdy, cal_done;
  logic strt_cal, mv_en, cal_busy, cal_ok, cal_err, src;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 parked, 1 settling, 2 start pulse, 3 awaiting result
  int   m_ph;
  int   m_settle_left, m_tmo_left, m_auto_left;
  bit   m_areq, m_pend, m_ok, m_err, m_src;

  cal_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_cal (cmd_cal),
    .auto_en (auto_en),
    .moving  (moving),
    .rdy     (rdy),
    .cal_done(cal_done),
    .strt_cal(strt_cal),
    .mv_en   (mv_en),
    .cal_busy(cal_busy),
    .cal_ok  (cal_ok),
    .cal_err (cal_err),
    .src     (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit c, input bit a, input bit mv, input bit r,
                            input bit d, input bit rs);
    bit parked, g_cmd, g_auto;
    if (rs) begin
      m_ph = 0; m_settle_left = SN; m_tmo_left = TN; m_auto_left = AN;
      m_areq = 0; m_pend = 0; m_ok = 0; m_err = 0; m_src = 0;
      return;
    end
    parked = (m_ph == 0);
    g_cmd  = parked && (c || m_pend);
    g_auto = parked && !g_cmd && m_areq;
    if (c && !parked) m_pend = 1;
    if (g_cmd || g_auto || mv || !a) m_auto_left = AN;
    else if (parked && m_ok && r && m_auto_left > 0) m_auto_left--;
    if (g_cmd || g_auto || mv) m_areq = 0;
    else if (m_auto_left == 0) m_areq = 1;
    if (m_ph == 0) begin
      if (g_cmd || g_auto) begin
        m_ph = 1; m_src = g_auto; m_settle_left = SN;
        if (g_cmd) m_pend = 0;
      end
    end else if (m_ph == 1) begin
      if (mv) m_settle_left = SN;
      else if (r && m_settle_left > 0) m_settle_left--;
      if (m_settle_left == 0) m_ph = 2;
    end else if (m_ph == 2) begin
      m_ph = 3; m_tmo_left = TN;
    end else begin
      if (d) begin
        m_ok = 1; m_err = 0; m_ph = 0;
      end else if (r) begin
        m_tmo_left--;
        if (m_tmo_left == 0) begin m_ok = 0; m_err = 1; m_ph = 0; end
      end
    end
  endtask

  task automatic tick(input logic c, input logic m, input logic r, input logic d);
    cmd_cal = c; moving = m; rdy = r; cal_done = d;
    @(posedge clk);
    model_step(c, auto_en, m, r, d, rst);
    #1;
  endtask

  task automatic run_to_wait();
    tick(1, 0, 0, 0);
    repeat (SN) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; auto_en = 0;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    checks++;
    if ({strt_cal, cal_busy, cal_ok, cal_err, src, mv_en} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 000001",
               {strt_cal, cal_busy, cal_ok, cal_err, src, mv_en});
    end
    rst = 0;
    tick(0, 0, 0, 0);
    checks++;
    if ({cal_busy, mv_en} !== 2'b00) begin
      errors++; $display("FAIL reset_idle: got %b exp 00", {cal_busy, mv_en});
    end
  endtask

  task automatic test_cmd_basic();
    int early = 0;
    auto_en = 0;
    tick(1, 0, 0, 0);
    checks++;
    if (cal_busy !== 1'b1) begin errors++; $display("FAIL cmd_grant: busy %b exp 1", cal_busy); end
    for (int k = 1; k <= SN; k++) begin
      repeat (9) begin
        tick(0, 0, 0, 0);
        if (strt_cal !== 1'b0) early++;
      end
      tick(0, 0, 1, 0);
      if (k < SN && strt_cal !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL cmd_early_strt: got %0d pulses exp 0", early); end
    checks++;
    if (strt_cal !== 1'b1) begin errors++; $display("FAIL cmd_strt_latency: got %b exp 1", strt_cal); end
    tick(0, 0, 0, 0);
    checks++;
    if ({strt_cal, cal_busy} !== 2'b01) begin
      errors++; $display("FAIL cmd_strt_width: got %b exp 01", {strt_cal, cal_busy});
    end
    repeat (28) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({cal_ok, cal_err, cal_busy, src} !== 4'b1000) begin
      errors++; $display("FAIL cmd_done: got %b exp 1000", {cal_ok, cal_err, cal_busy, src});
    end
  endtask

  task automatic test_settle_restart();
    int bad = 0;
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1'(i % 2), 0);
      if ({mv_en, strt_cal} !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL settle_moving: got %0d bad cycles exp 0", bad); end
    for (int k = 1; k <= SN; k++) begin
      tick(0, 0, 1, 0);
      checks++;
      if (strt_cal !== (k == SN)) begin
        errors++; $display("FAIL settle_restart_rdy%0d: strt %b exp %b", k, strt_cal, k == SN);
      end
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({cal_busy, cal_ok} !== 2'b01) begin
      errors++; $display("FAIL settle_done: got %b exp 01", {cal_busy, cal_ok});
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    run_to_wait();
    for (int i = 0; i < TN - 1; i++) begin
      tick(0, 1'($urandom % 2), 1, 0);
      if (cal_busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tmo_early: got %0d idle cycles exp 0", bad); end
    tick(0, 0, 1, 0);
    checks++;
    if ({cal_busy, cal_ok, cal_err} !== 3'b001) begin
      errors++; $display("FAIL tmo_expire: got %b exp 001", {cal_busy, cal_ok, cal_err});
    end
    run_to_wait();
    repeat (TN - 1) tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    checks++;
    if ({cal_busy, cal_ok, cal_err} !== 3'b010) begin
      errors++; $display("FAIL tmo_done_wins: got %b exp 010", {cal_busy, cal_ok, cal_err});
    end
  endtask

  task automatic test_auto();
    int extra = 0;
    auto_en = 1;
    repeat (AN) tick(0, 0, 1, 0);
    checks++;
    if (cal_busy !== 1'b0) begin errors++; $display("FAIL auto_early: busy %b exp 0", cal_busy); end
    tick(0, 0, 0, 0);
    checks++;
    if ({cal_busy, src} !== 2'b11) begin
      errors++; $display("FAIL auto_grant: got %b exp 11", {cal_busy, src});
    end
    repeat (SN) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({cal_busy, cal_ok, src} !== 3'b011) begin
      errors++; $display("FAIL auto_done: got %b exp 011", {cal_busy, cal_ok, src});
    end
    auto_en = 0;
    tick(0, 0, 0, 0);
    checks++;
    if ({cal_busy, src} !== 2'b10) begin
      errors++; $display("FAIL pend_grant: got %b exp 10", {cal_busy, src});
    end
    repeat (SN) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    repeat (6) begin
      tick(0, 0, 0, 0);
      if (cal_busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL pend_one_deep: got %0d busy cycles exp 0", extra); end
  endtask

  task automatic test_coincide();
    int pulses = 0;
    int busy_after = 0;
    auto_en = 1;
    repeat (AN) tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    checks++;
    if ({cal_busy, src} !== 2'b10) begin
      errors++; $display("FAIL coincide_src: got %b exp 10", {cal_busy, src});
    end
    repeat (SN) begin tick(0, 0, 1, 0); pulses += int'(strt_cal); end
    repeat (3) begin tick(0, 0, 0, 0); pulses += int'(strt_cal); end
    tick(0, 0, 0, 1);
    repeat (6) begin
      tick(0, 0, 0, 0);
      pulses += int'(strt_cal);
      busy_after += int'(cal_busy);
    end
    checks++;
    if (pulses != 1 || busy_after != 0) begin
      errors++;
      $display("FAIL coincide_once: strt %0d busy_after %0d exp 1 0", pulses, busy_after);
    end
    auto_en = 0;
  endtask

  task automatic test_rst_wait();
    run_to_wait();
    rst = 1;
    tick(0, 0, 0, 0);
    rst = 0;
    checks++;
    if ({strt_cal, cal_busy, cal_ok, cal_err, src, mv_en} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_wait: got %b exp 000000",
               {strt_cal, cal_busy, cal_ok, cal_err, src, mv_en});
    end
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    checks++;
    if ({strt_cal, cal_busy, cal_ok, cal_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_late_done: got %b exp 0000", {strt_cal, cal_busy, cal_ok, cal_err});
    end
  endtask

  task automatic test_random();
    logic       mv_r;
    logic [5:0] got, exp;
    mv_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if (mv_r) mv_r = ($urandom_range(0, 4) != 0);
      else      mv_r = ($urandom_range(0, 79) == 0);
      auto_en = ($urandom_range(0, 19) != 0);
      rst     = ($urandom_range(0, 799) == 0);
      tick($urandom_range(0, 99) == 0, mv_r, 1'($urandom_range(0, 1)),
           $urandom_range(0, 24) == 0);
      got = {strt_cal, cal_busy, cal_ok, cal_err, src, mv_en};
      exp = {m_ph == 2, m_ph != 0, m_ok, m_err, m_src, mv_r && (m_ph == 0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: {strt,busy,ok,err,src,mv_en} got %b exp %b", i, got, exp);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; cmd_cal = 0; auto_en = 0; moving = 0; rdy = 0; cal_done = 0;
    test_reset();
    test_cmd_basic();
    test_settle_restart();
    test_timeout();
    test_auto();
    test_coincide();
    test_rst_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
